alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Most operations return one cycle after accept. MUL runs a shift-add
// multiplier over WIDTH cycles. While it runs, no new requests are taken.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int BR_W  = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [BR_W-1:0]  branch_addr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             co_flag,
   output logic             eq_flag,
   output logic             branch_flag,
   output logic             br_taken
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;
   localparam logic [3:0] OP_BEQ = 4'd7;
   localparam logic [3:0] OP_XOR = 4'd8;
   localparam logic [3:0] OP_INC = 4'd9;
   localparam logic [3:0] OP_DEC = 4'd10;
   localparam logic [3:0] OP_ADC = 4'd11;
   localparam logic [3:0] OP_SHL = 4'd12;
   localparam logic [3:0] OP_SHR = 4'd13;
   localparam logic [3:0] OP_MUL = 4'd14;

   typedef enum logic [1:0] {
      IDLE,
      MUL_BUSY,
      MUL_DONE
   } state_t;

   state_t state;

   logic [WIDTH:0]     a_ext;
   logic [WIDTH:0]     b_ext;
   logic [WIDTH:0]     one_ext;
   logic [WIDTH:0]     carry_ext;
   logic [WIDTH:0]     wide;
   logic [WIDTH-1:0]   br_ext;
   logic [WIDTH-1:0]   alu_out;
   logic               alu_co;
   logic               alu_eq;
   logic               alu_br;
   logic               alu_tk;
   logic               alu_load;
   logic               accept;
   logic               out_free;

   logic [2*WIDTH-1:0] mul_acc;
   logic [2*WIDTH-1:0] mul_mcand;
   logic [WIDTH-1:0]   mul_mplier;
   logic [CNT_W-1:0]   mul_cnt;

   assign a_ext     = {1'b0, A};
   assign b_ext     = {1'b0, B};
   assign one_ext   = {{WIDTH{1'b0}}, 1'b1};
   assign carry_ext = {{WIDTH{1'b0}}, co_flag};
   assign out_free  = !out_valid || out_ready;
   assign in_ready  = (state == IDLE) && out_free;
   assign accept    = in_valid && in_ready;

   // Single-cycle ALU: computes the result and flags for every non-MUL opcode.
   // Arithmetic is WIDTH+1 bits wide, so the top bit is the carry or borrow.
   always_comb begin
      wide     = '0;
      br_ext   = '0;
      br_ext[BR_W-1:0] = branch_addr;
      alu_out  = '0;
      alu_co   = 1'b0;
      alu_eq   = 1'b0;
      alu_br   = 1'b0;
      alu_tk   = 1'b0;
      alu_load = 1'b1;
      case (opcode)
         OP_ADD: begin
            wide    = a_ext + b_ext;
            alu_out = wide[WIDTH-1:0];
            alu_co  = wide[WIDTH];
         end
         OP_SUB: begin
            wide    = a_ext - b_ext;
            alu_out = wide[WIDTH-1:0];
            alu_co  = wide[WIDTH];
         end
         OP_AND: alu_out = A & B;
         OP_NOT: alu_out = ~A;
         OP_OR:  alu_out = A | B;
         OP_CMP: begin
            alu_out[0] = (A == B);
            alu_eq     = (A == B);
         end
         OP_BEQ: begin
            alu_br  = 1'b1;
            alu_tk  = eq_flag;
            alu_out = eq_flag ? br_ext : '0;
         end
         OP_XOR: alu_out = A ^ B;
         OP_INC: begin
            wide    = a_ext + one_ext;
            alu_out = wide[WIDTH-1:0];
            alu_co  = wide[WIDTH];
         end
         OP_DEC: begin
            wide    = a_ext - one_ext;
            alu_out = wide[WIDTH-1:0];
            alu_co  = wide[WIDTH];
         end
         OP_ADC: begin
            wide    = a_ext + b_ext + carry_ext;
            alu_out = wide[WIDTH-1:0];
            alu_co  = wide[WIDTH];
         end
         OP_SHL: begin
            wide    = {A, 1'b0};
            alu_out = wide[WIDTH-1:0];
            alu_co  = wide[WIDTH];
         end
         OP_SHR: begin
            wide    = {A[0], 1'b0, A[WIDTH-1:1]};
            alu_out = wide[WIDTH-1:0];
            alu_co  = wide[WIDTH];
         end
         default: alu_load = 1'b0;
      endcase
   end

   // Control FSM, result register and multiplier datapath.
   // Reset overrides accept, consume and MUL completion.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         out         <= '0;
         out_valid   <= 1'b0;
         co_flag     <= 1'b0;
         eq_flag     <= 1'b0;
         branch_flag <= 1'b0;
         br_taken    <= 1'b0;
         mul_acc     <= '0;
         mul_mcand   <= '0;
         mul_mplier  <= '0;
         mul_cnt     <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (opcode == OP_MUL) begin
                     mul_acc    <= '0;
                     mul_mcand  <= {{WIDTH{1'b0}}, A};
                     mul_mplier <= B;
                     mul_cnt    <= '0;
                     state      <= MUL_BUSY;
                  end else if (alu_load) begin
                     out         <= alu_out;
                     co_flag     <= alu_co;
                     eq_flag     <= alu_eq;
                     branch_flag <= alu_br;
                     br_taken    <= alu_tk;
                     out_valid   <= 1'b1;
                  end
               end
            end
            MUL_BUSY: begin
               if (mul_mplier[0]) begin
                  mul_acc <= mul_acc + mul_mcand;
               end
               mul_mcand  <= mul_mcand << 1;
               mul_mplier <= mul_mplier >> 1;
               mul_cnt    <= mul_cnt + 1'b1;
               if (mul_cnt == CNT_W'(WIDTH - 1)) begin
                  state <= MUL_DONE;
               end
            end
            MUL_DONE: begin
               if (out_free) begin
                  out         <= mul_acc[WIDTH-1:0];
                  co_flag     <= |mul_acc[2*WIDTH-1:WIDTH];
                  eq_flag     <= 1'b0;
                  branch_flag <= 1'b0;
                  br_taken    <= 1'b0;
                  out_valid   <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe with WIDTH=8 and BR_W=6.
// The stimulus process pushes expected results into a scoreboard queue.
// The monitor pops an entry each time a result is consumed.
module tb_alu_pipe;

   logic       CLK;
   logic       RST;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [7:0] A;
   logic [7:0] B;
   logic [5:0] branch_addr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic       co_flag;
   logic       eq_flag;
   logic       branch_flag;
   logic       br_taken;

   typedef struct {
      string      name;
      logic [7:0] res;
      logic       co;
      logic       eq;
      logic       br;
      logic       tk;
   } exp_t;

   exp_t sb[$];
   exp_t mon_exp;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic seen_valid;

   alu_pipe #(.WIDTH(8), .BR_W(6)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .A(A), .B(B), .branch_addr(branch_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .co_flag(co_flag), .eq_flag(eq_flag), .branch_flag(branch_flag),
      .br_taken(br_taken)
   );

   // Free-running clock with a 10-time-unit period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Watchdog that stops a run that stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pushExpect(input string name, input logic [7:0] res,
                             input logic co, input logic eq, input logic br, input logic tk);
      exp_t e;
      e.name = name; e.res = res; e.co = co; e.eq = eq; e.br = br; e.tk = tk;
      sb.push_back(e);
   endtask

   // Called at posedge+1. Holds the request until it is accepted, then returns at posedge+1.
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [5:0] br);
      bit acc;
      int waited;
      acc = 1'b0;
      waited = 0;
      in_valid = 1'b1; opcode = op; A = a; B = b; branch_addr = br;
      while (!acc && waited < 50) begin
         @(negedge CLK);
         acc = in_ready;
         @(posedge CLK);
         #1;
         waited++;
      end
      if (!acc) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL accept_timeout: got in_ready=0, expected acceptance of opcode %0d", op);
      end
      in_valid = 1'b0;
   endtask

   // Issues a single-cycle op and checks that the result appears one cycle after accept.
   task automatic runOp(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [5:0] br, input logic [7:0] res,
                        input logic co, input logic eq, input logic bf, input logic tk);
      pushExpect(name, res, co, eq, bf, tk);
      applyStimulus(op, a, b, br);
      @(negedge CLK);
      checkOutput({name, "_latency"}, out_valid, 1);
      @(posedge CLK);
      #1;
   endtask

   // Monitor: compares each consumed result against the scoreboard head.
   initial begin
      forever begin
         @(negedge CLK);
         if (out_valid === 1'b1 && out_ready === 1'b1 && RST === 1'b0) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_result: got out=%0h, expected no result", out);
            end else begin
               mon_exp = sb.pop_front();
               checkOutput({mon_exp.name, "_out"}, out, mon_exp.res);
               checkOutput({mon_exp.name, "_co"}, co_flag, mon_exp.co);
               checkOutput({mon_exp.name, "_eq"}, eq_flag, mon_exp.eq);
               checkOutput({mon_exp.name, "_branch"}, branch_flag, mon_exp.br);
               checkOutput({mon_exp.name, "_taken"}, br_taken, mon_exp.tk);
            end
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; A = '0; B = '0; branch_addr = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("rst_out", out, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_flags", {co_flag, eq_flag, branch_flag, br_taken}, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      @(posedge CLK);
      #1;

      runOp("add",   4'd1,  8'd200, 8'd100, 6'd0,    8'd44,  1, 0, 0, 0);
      runOp("adc",   4'd11, 8'd1,   8'd1,   6'd0,    8'd3,   0, 0, 0, 0);
      runOp("sub",   4'd2,  8'd5,   8'd7,   6'd0,    8'd254, 1, 0, 0, 0);
      runOp("dec",   4'd10, 8'd0,   8'd0,   6'd0,    8'd255, 1, 0, 0, 0);
      runOp("cmp_eq",4'd6,  8'd9,   8'd9,   6'd0,    8'd1,   0, 1, 0, 0);
      runOp("beq_t", 4'd7,  8'd0,   8'd0,   6'h2A,   8'h2A,  0, 0, 1, 1);
      runOp("beq_n", 4'd7,  8'd0,   8'd0,   6'h2A,   8'h00,  0, 0, 1, 0);
      runOp("and",   4'd3,  8'hF0,  8'h3C,  6'd0,    8'h30,  0, 0, 0, 0);
      runOp("not",   4'd4,  8'h0F,  8'h00,  6'd0,    8'hF0,  0, 0, 0, 0);
      runOp("or",    4'd5,  8'hA0,  8'h05,  6'd0,    8'hA5,  0, 0, 0, 0);
      runOp("xor",   4'd8,  8'hFF,  8'h0F,  6'd0,    8'hF0,  0, 0, 0, 0);
      runOp("inc",   4'd9,  8'hFF,  8'h00,  6'd0,    8'h00,  1, 0, 0, 0);

      applyStimulus(4'd0, 8'h12, 8'h34, 6'd0);
      @(negedge CLK);
      checkOutput("nop_valid", out_valid, 0);
      checkOutput("nop_co_kept", co_flag, 1);
      @(posedge CLK);
      #1;
      applyStimulus(4'd15, 8'h12, 8'h34, 6'd0);
      @(negedge CLK);
      checkOutput("rsv_valid", out_valid, 0);
      checkOutput("rsv_co_kept", co_flag, 1);
      @(posedge CLK);
      #1;

      runOp("shl",   4'd12, 8'h81,  8'h00,  6'd0,    8'h02,  1, 0, 0, 0);
      runOp("shr",   4'd13, 8'h81,  8'h00,  6'd0,    8'h40,  1, 0, 0, 0);
      runOp("cmp_ne",4'd6,  8'd3,   8'd4,   6'd0,    8'h00,  0, 0, 0, 0);

      pushExpect("mul_15x17", 8'd255, 0, 0, 0, 0);
      applyStimulus(4'd14, 8'd15, 8'd17, 6'd0);
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         checkOutput($sformatf("mul_busy_ready_%0d", c), in_ready, 0);
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      checkOutput("mul_valid_early", out_valid, 0);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      checkOutput("mul_valid_at_9", out_valid, 1);
      @(posedge CLK);
      #1;

      pushExpect("mul_16x16", 8'd0, 1, 0, 0, 0);
      applyStimulus(4'd14, 8'd16, 8'd16, 6'd0);
      repeat (12) @(posedge CLK);
      #1;

      out_ready = 1'b0;
      pushExpect("bp_add", 8'd7, 0, 0, 0, 0);
      applyStimulus(4'd1, 8'd3, 8'd4, 6'd0);
      in_valid = 1'b1; opcode = 4'd8; A = 8'h55; B = 8'h0F; branch_addr = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         checkOutput("bp_in_ready", in_ready, 0);
         checkOutput("bp_valid", out_valid, 1);
         checkOutput("bp_out_stable", out, 8'd7);
         @(posedge CLK);
         #1;
      end
      pushExpect("bp_xor", 8'h5A, 0, 0, 0, 0);
      out_ready = 1'b1;
      @(negedge CLK);
      checkOutput("bp_release_ready", in_ready, 1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      @(negedge CLK);
      checkOutput("bp_b2b_valid", out_valid, 1);
      checkOutput("bp_b2b_out", out, 8'h5A);
      @(posedge CLK);
      #1;

      runOp("inc_pre_rst", 4'd9, 8'hFF, 8'h00, 6'd0, 8'h00, 1, 0, 0, 0);
      applyStimulus(4'd14, 8'd5, 8'd5, 6'd0);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("mrst_valid", out_valid, 0);
      checkOutput("mrst_flags", {co_flag, eq_flag, branch_flag, br_taken}, 0);
      checkOutput("mrst_out", out, 0);
      checkOutput("mrst_in_ready", in_ready, 1);
      seen_valid = 1'b0;
      repeat (15) begin
         @(negedge CLK);
         if (out_valid) seen_valid = 1'b1;
      end
      checkOutput("mrst_no_result", seen_valid, 0);
      checkOutput("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
